// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset synchroniser/sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    HOLD = 2'd1,
    SEQ  = 2'd2,
    DONE = 2'd3
  } rst_state_e;

  // Larger of two values; used to size the shared hold/gap counter.
  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Async-clear, sync-release reset synchroniser chain.
module rst_sync_cell
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_async_n,
  output logic sync_n
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift a constant one in from the LSB end.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  // Chain flops: cleared at once by reset, released one stage per clock.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchroniser and sequencer for one clock domain.
// Synchronised release, MIN_HOLD-cycle hold, then channels released in
// order 0..NUM_CH-1 spaced RELEASE_GAP cycles apart.
// Optional feature macro: RST_SEQ_SW_RESET_EN adds sw_rst_req_i, a
// clk-synchronous software reset that returns the sequencer to HOLD.
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HOLD    = 4,
  parameter int unsigned RELEASE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_async_n,
`ifdef RST_SEQ_SW_RESET_EN
  input  logic              sw_rst_req_i,
`endif
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              rst_done_o
);

  localparam int unsigned CW = $clog2(max(MIN_HOLD, RELEASE_GAP) + 1);
  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);

  logic              sync_n;
  logic              sw_req;

  rst_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;

  rst_sync_cell #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .sync_n      (sync_n)
  );

`ifdef RST_SEQ_SW_RESET_EN
  assign sw_req = sw_rst_req_i;
`else
  assign sw_req = 1'b0;
`endif

  // Next-state, counter, channel index and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;

    unique case (state_q)
      RST: begin
        cnt_d   = '0;
        ch_d    = '0;
        rst_n_d = '0;
        done_d  = 1'b0;
        if (sync_n) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          ch_d    = '0;
          rst_n_d = NUM_CH'(1);
          if (NUM_CH == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEQ;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEQ: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          ch_d  = ch_q + 1'b1;
          // Outputs stay thermometer-coded: shift one more released bit in.
          rst_n_d = NUM_CH'({rst_n_q, 1'b1});
          if (ch_d == LAST_CH) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RST;
      end
    endcase

    // Software request overrides the sequence everywhere except RST.
    if (sw_req && (state_q != RST)) begin
      state_d = HOLD;
      cnt_d   = '0;
      ch_d    = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end
  end

  // Sequencer state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= RST;
      cnt_q   <= '0;
      ch_q    <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_o    = rst_n_q;
  assign rst_done_o = done_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: default instance plus a NUM_CH=1/SYNC_STAGES=3/
// MIN_HOLD=1 instance sharing clock and reset.
module tb_rst_seq_sync;

  logic       clk = 1'b0;
  logic       rst_async_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [3:0] rst_n;
  logic       done;
  logic [0:0] rst1;
  logic       done1;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned mon_errors = 0;
  int unsigned rst_events = 0;

  always #5 clk = ~clk;

  rst_seq_sync dut (
    .clk          (clk),
    .rst_async_n  (rst_async_n),
`ifdef RST_SEQ_SW_RESET_EN
    .sw_rst_req_i (sw_rst_req),
`endif
    .rst_n_o      (rst_n),
    .rst_done_o   (done)
  );

  rst_seq_sync #(
    .NUM_CH      (1),
    .SYNC_STAGES (3),
    .MIN_HOLD    (1),
    .RELEASE_GAP (2)
  ) dut1 (
    .clk          (clk),
    .rst_async_n  (rst_async_n),
`ifdef RST_SEQ_SW_RESET_EN
    .sw_rst_req_i (sw_rst_req),
`endif
    .rst_n_o      (rst1),
    .rst_done_o   (done1)
  );

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  exp_rst;
    logic        exp_done;
    logic        exp_rst1;
    logic        exp_done1;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Release at a falling edge so the next rising edge is edge 1.
  task automatic release_rst();
    @(negedge clk);
    rst_async_n = 1'b1;
  endtask

  task automatic run_table();
    int unsigned cur = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].edge_n) begin
        @(posedge clk);
        cur++;
      end
      #1;
      check($sformatf("tbl_rst@%0d", tbl[i].edge_n), 32'(rst_n), 32'(tbl[i].exp_rst));
      check($sformatf("tbl_done@%0d", tbl[i].edge_n), 32'(done), 32'(tbl[i].exp_done));
      check($sformatf("tbl_rst1@%0d", tbl[i].edge_n), 32'(rst1), 32'(tbl[i].exp_rst1));
      check($sformatf("tbl_done1@%0d", tbl[i].edge_n), 32'(done1), 32'(tbl[i].exp_done1));
    end
  endtask

  always @(negedge rst_async_n) rst_events++;

  // Thermometer coding, done consistency and monotonic release.
  logic [3:0]  prev_rst = 4'h0;
  int unsigned prev_events = 0;
  logic        prev_sw = 1'b0;
  always @(negedge clk) begin
    logic [3:0] inc;
    inc = rst_n + 4'd1;
    if ((inc & rst_n) != 4'h0) begin
      mon_errors++;
      $display("FAIL mon_thermo: got %b expected thermometer code at %0t", rst_n, $time);
    end
    if (done !== (rst_n == 4'hF)) begin
      mon_errors++;
      $display("FAIL mon_done: got %b expected %b at %0t", done, (rst_n == 4'hF), $time);
    end
    if (done1 !== rst1[0]) begin
      mon_errors++;
      $display("FAIL mon_done1: got %b expected %b at %0t", done1, rst1[0], $time);
    end
    if ((rst_events == prev_events) && !prev_sw && ((prev_rst & ~rst_n) != 4'h0)) begin
      mon_errors++;
      $display("FAIL mon_monotonic: got %b expected no drop from %b at %0t", rst_n, prev_rst, $time);
    end
    prev_rst    = rst_n;
    prev_events = rst_events;
    prev_sw     = sw_rst_req;
  end

  initial begin
    tbl[0]  = '{1,  4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4,  4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{5,  4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{6,  4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{7,  4'b0001, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{8,  4'b0001, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{9,  4'b0011, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{10, 4'b0011, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{11, 4'b0111, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{12, 4'b0111, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{13, 4'b1111, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{15, 4'b1111, 1'b1, 1'b1, 1'b1};

    // Reset state while held low.
    #1 rst_async_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rst", 32'(rst_n), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_rst1", 32'(rst1), 32'h0);
    check("reset_done1", 32'(done1), 32'h0);

    // Basic release sequence.
    release_rst();
    run_table();

    // Short glitch in DONE clears outputs without a clock edge.
    @(negedge clk);
    #1 rst_async_n = 1'b0;
    #1;
    check("glitch_rst", 32'(rst_n), 32'h0);
    check("glitch_done", 32'(done), 32'h0);
    check("glitch_rst1", 32'(rst1), 32'h0);
    #1 rst_async_n = 1'b1;
    run_table();

    // Reset asserted mid-sequence at edge 10.
    @(negedge clk);
    #1 rst_async_n = 1'b0;
    release_rst();
    repeat (10) @(posedge clk);
    #1;
    check("mid_pre_rst", 32'(rst_n), 32'h3);
    #1 rst_async_n = 1'b0;
    #1;
    check("mid_rst", 32'(rst_n), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_hold_done", 32'(done), 32'h0);
    release_rst();
    run_table();

`ifdef RST_SEQ_SW_RESET_EN
    // Software request high for three sampled edges while in DONE.
    @(posedge clk);
    #2 sw_rst_req = 1'b1;
    @(posedge clk);
    #1;
    check("sw_rst", 32'(rst_n), 32'h0);
    check("sw_done", 32'(done), 32'h0);
    check("sw_rst1", 32'(rst1), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("sw_held_rst", 32'(rst_n), 32'h0);
    #1 sw_rst_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        check("sw_rst1_rise", 32'(rst1), 32'h1);
        check("sw_done1_rise", 32'(done1), 32'h1);
      end
      if (k == 3) check("sw_k3", 32'(rst_n), 32'h0);
      if (k == 4) check("sw_k4", 32'(rst_n), 32'h1);
      if (k == 6) check("sw_k6", 32'(rst_n), 32'h3);
      if (k == 8) check("sw_k8", 32'(rst_n), 32'h7);
      if (k == 9) check("sw_k9_done", 32'(done), 32'h0);
      if (k == 10) begin
        check("sw_k10", 32'(rst_n), 32'hF);
        check("sw_k10_done", 32'(done), 32'h1);
      end
    end
`endif

    // Random reset pulses with the monitor watching.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #($urandom_range(1, 4));
      rst_async_n = 1'b0;
      #($urandom_range(1, 15));
      rst_async_n = 1'b1;
    end

    // Clean restart, bounded wait for completion.
    @(negedge clk);
    #1 rst_async_n = 1'b0;
    release_rst();
    begin
      int unsigned n = 0;
      while (!done && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("final_done", 32'(done), 32'h1);
      check("final_edge", 32'(n), 32'd13);
    end

    check("monitor_errors", 32'(mon_errors), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
